// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: req/ack data-memory transaction with pipeline stall,
// store lane steering, load extraction/extension, misalignment and timeout reporting.
module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] ALU_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  mem_stall,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  mem_done,
  output logic                  misaligned,
  output logic                  bus_error
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;

  logic                  start;
  logic                  is_byte, is_half;
  logic                  aligned;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [3:0]            st_wstrb;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] rd_ext;

  // Decode of the incoming EX/MEM op; unused funct3 codes fall through to word size.
  always_comb begin
    start    = op_valid & (MemRead | MemWrite);
    is_byte  = (funct3[1:0] == 2'b00);
    is_half  = (funct3[1:0] == 2'b01);
    aligned  = 1'b1;
    st_wdata = store_data;
    st_wstrb = 4'b1111;
    if (is_byte) begin
      st_wdata = {4{store_data[7:0]}};
      st_wstrb = 4'b0001 << ALU_result[1:0];
    end else if (is_half) begin
      aligned  = ~ALU_result[0];
      st_wdata = {2{store_data[15:0]}};
      st_wstrb = 4'b0011 << ALU_result[1:0];
    end else begin
      aligned  = (ALU_result[1:0] == 2'b00);
    end
  end

  // Load extraction works on the latched offset and width, not the live inputs.
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = dmem_rdata[7:0];
      2'd1:    rd_byte = dmem_rdata[15:8];
      2'd2:    rd_byte = dmem_rdata[23:16];
      default: rd_byte = dmem_rdata[31:24];
    endcase
    rd_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = '0;
    dmem_wdata  = '0;
    dmem_wstrb  = 4'b0000;
    mem_stall   = 1'b0;
    mem_done    = 1'b0;
    misaligned  = 1'b0;
    bus_error   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!aligned) begin
            misaligned = 1'b1;
            state_d    = DONE;
          end else begin
            mem_stall = 1'b1;
            cnt_d     = 8'd0;
            addr_d    = {ALU_result[ADDR_WIDTH-1:2], 2'b00};
            off_d     = ALU_result[1:0];
            funct3_d  = funct3;
            we_d      = ~MemRead;
            wdata_d   = MemRead ? '0 : st_wdata;
            wstrb_d   = MemRead ? 4'b0000 : st_wstrb;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        dmem_req   = 1'b1;
        mem_stall  = 1'b1;
        dmem_we    = we_q;
        dmem_addr  = addr_q;
        dmem_wdata = wdata_q;
        dmem_wstrb = wstrb_q;
        cnt_d      = cnt_q + 8'd1;
        // An ack arriving in the final allowed cycle still counts as success.
        if (dmem_ack) begin
          if (!we_q) load_data_d = rd_ext;
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          bus_error = 1'b1;
          if (!we_q) load_data_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        mem_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= 4'b0000;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
    end
  end

  assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus random loads/stores,
// with a memory responder and a monitor comparing against queued expectations.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        op_valid, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALU_result, store_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall, mem_done, misaligned, bus_error;
  logic [31:0] load_data;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALU_result(ALU_result), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .load_data(load_data), .mem_done(mem_done),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] ld;
    int          req_cycles;
    int          stall;
    int          mis;
    int          berr;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_ld = 0;
  int          cur_delay = 255;
  logic [31:0] cur_rdata = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: acks on the (delay+1)-th request cycle, random rdata otherwise.
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (dmem_req && rst_n) begin
      busy_cnt++;
      if (cur_delay != 255 && busy_cnt == cur_delay + 1) begin
        dmem_ack   = 1'b1;
        dmem_rdata = cur_rdata;
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
      end
    end else begin
      busy_cnt = 0;
      dmem_ack = 1'b0;
    end
  end

  // Monitor: per-cycle request checks and per-transaction summary at mem_done.
  int  req_cycles = 0, stall_cnt = 0, mis_cnt = 0, berr_cnt = 0, gap = 100;
  bit  prev_req = 0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      req_cycles = 0; stall_cnt = 0; mis_cnt = 0; berr_cnt = 0; gap = 100; prev_req = 0;
    end else begin
      if (dmem_req) begin
        if (!prev_req) check("req_gap", (gap >= 2), 1'b1);
        if (sb.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL req_noexp: got request with empty scoreboard");
        end else begin
          check("req_fields", {dmem_addr, dmem_we, dmem_wdata, dmem_wstrb},
                {sb[0].addr, sb[0].we, sb[0].wdata, sb[0].wstrb});
        end
        req_cycles++;
        gap = 0;
      end else begin
        gap++;
      end
      prev_req = dmem_req;
      if (mem_stall)  stall_cnt++;
      if (misaligned) mis_cnt++;
      if (bus_error)  berr_cnt++;
      if (mem_done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL done_noexp: got mem_done with empty scoreboard");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("load_data",  load_data,  e.ld);
          check("req_cycles", req_cycles, e.req_cycles);
          check("stall_cyc",  stall_cnt,  e.stall);
          check("misaligned", mis_cnt,    e.mis);
          check("bus_error",  berr_cnt,   e.berr);
        end
        req_cycles = 0; stall_cnt = 0; mis_cnt = 0; berr_cnt = 0;
      end
    end
  end

  function automatic logic [31:0] extract(input logic [2:0] f3, input int size, input int off,
                                          input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * off);
    if (size == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // Computes the expected outcome from the access rules and issues the op.
  task automatic applyStimulus(input bit mr, input bit mw, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rdata, input int delay);
    exp_t e;
    int   size, off;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(addr % 4);
    e = '{req: 0, addr: 0, we: 0, wdata: 0, wstrb: 0, ld: 0, req_cycles: 0, stall: 0, mis: 0, berr: 0};
    if (addr % size != 0) begin
      e.mis = 1;
    end else begin
      e.req  = 1;
      e.addr = addr & ~32'h3;
      e.we   = !mr;
      if (!mr) begin
        e.wstrb = 4'(((1 << size) - 1) << off);
        for (int j = 0; j < 4; j++) e.wdata[8*j +: 8] = sdata[8*(j % size) +: 8];
      end
      if (delay <= TO - 1) begin
        e.req_cycles = delay + 1;
        e.stall      = delay + 2;
        if (mr) model_ld = extract(f3, size, off, rdata);
      end else begin
        e.req_cycles = TO;
        e.stall      = TO + 1;
        e.berr       = 1;
        if (mr) model_ld = 0;
      end
    end
    e.ld = model_ld;
    sb.push_back(e);
    cur_delay  = delay;
    cur_rdata  = rdata;
    op_valid   = 1'b1;
    MemRead    = mr;
    MemWrite   = mw;
    funct3     = f3;
    ALU_result = addr;
    store_data = sdata;
  endtask

  // Waits for mem_done, scrambling the live inputs while the access is in flight.
  task automatic waitDone();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (dmem_req) begin
        ALU_result = $urandom;
        store_data = $urandom;
        funct3     = 3'($urandom_range(0, 7));
        MemRead    = 1'($urandom_range(0, 1));
        MemWrite   = 1'($urandom_range(0, 1));
      end
      #2;
      if (mem_done) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("[TB] FAIL done_wait: got no mem_done within 60 cycles, expected one");
    end
    op_valid = 1'b0;
  endtask

  task automatic runOp(input bit mr, input bit mw, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdata, input int delay);
    @(negedge clk);
    #1;
    applyStimulus(mr, mw, f3, addr, sdata, rdata, delay);
    waitDone();
  endtask

  task automatic checkOutput(input string name);
    check(name, {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, mem_stall,
                 mem_done, misaligned, bus_error, load_data}, '0);
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    ALU_result = 0; store_data = 0; dmem_ack = 1'b0; dmem_rdata = 0;
    repeat (3) @(negedge clk);
    #3;
    checkOutput("reset_outs");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    runOp(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 2);
    runOp(0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 1);
    runOp(1, 0, 3'b000, 32'h103, 0, 32'hA500_0000, 1);
    runOp(1, 0, 3'b100, 32'h103, 0, 32'hA500_0000, 0);
    runOp(1, 0, 3'b001, 32'h102, 0, 32'h8001_1234, TO - 1);
    runOp(1, 0, 3'b101, 32'h102, 0, 32'h8001_1234, 1);
    runOp(1, 0, 3'b010, 32'h102, 0, 32'h1234_5678, 0);
    runOp(0, 1, 3'b001, 32'h101, 32'h0000_BEEF, 0, 0);
    runOp(1, 0, 3'b010, 32'h200, 0, 32'hCAFE_F00D, 255);
    runOp(1, 1, 3'b110, 32'h204, 32'h1111_2222, 32'h7654_3210, 0);

    // Abort an in-flight access with reset, then confirm a fresh load works.
    @(negedge clk);
    #1;
    applyStimulus(1, 0, 3'b010, 32'h300, 0, 0, 255);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    #1;
    check("rst_req",   dmem_req,  1'b0);
    check("rst_stall", mem_stall, 1'b0);
    check("rst_ld",    load_data, 32'h0);
    sb.delete();
    model_ld = 0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    runOp(1, 0, 3'b010, 32'h400, 0, 32'h0BAD_CAFE, 1);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3;
      logic [31:0] addr;
      int          sel, d, size;
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if ($urandom_range(0, 2) != 0) addr = addr & ~32'(size - 1);
      sel  = $urandom_range(1, 3);
      d    = $urandom_range(0, TO);
      if (d == TO) d = 255;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      runOp(sel[0], sel[1], f3, addr, $urandom, $urandom, d);
    end

    repeat (3) @(negedge clk);
    #3;
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
